procyon_biu_wb_master: RTL and testbench
========================================

// Module: procyon_biu_wb_master
// PURPOSE
// - Bus master bridging the core-side BIU request interface to a Wishbone B4 registered-feedback bus.
// - Converts one BIU request (READ/WRITE/RMW, 1B..128B) into a classic or incrementing-burst WB cycle.
// - Streams per-beat data and signals completion back to the requester (cache/fetch miss path).
// PARAMETERS
// - OPTN_DATA_WIDTH  32  WB data width in bits; power of two, 8..128
// - OPTN_ADDR_WIDTH  32  byte address width
// PORTS
// - clk          in   1        sole clock
// - n_rst        in   1        reset, asynchronous, active-low
// - i_biu_en     in   1        request valid; held high until o_biu_done
// - i_biu_func   in   2        PCYN_BIU_FUNC_{READ,WRITE,RMW}
// - i_biu_len    in   3        PCYN_BIU_LEN_1B..128B
// - i_biu_addr   in   AW       request byte address
// - i_biu_sel    in   DW/8     byte enables, single-beat requests only
// - i_biu_data   in   DW       write/RMW data for current beat
// - o_biu_ack    out  1        beat handshake: write data sampled / read data valid
// - o_biu_data   out  DW       read data, valid when o_biu_ack on reads
// - o_biu_done   out  1        one-cycle completion pulse
// - o_biu_err    out  1        qualifies o_biu_done: bus error
// - o_wb_cyc/o_wb_stb/o_wb_we  out 1 each   WB cycle, strobe, write-enable
// - o_wb_cti     out  3        WB_CTI_*
// - o_wb_bte     out  2        always WB_BTE_LINEAR
// - o_wb_adr     out  AW       beat byte address, aligned to DW/8
// - o_wb_sel     out  DW/8     byte lanes
// - o_wb_dat     out  DW       write data
// - i_wb_ack/i_wb_err  in 1 each   slave termination
// - i_wb_dat     in   DW       read data
// BEHAVIOUR
// - Reset: FSM=IDLE; all outputs 0; beat counter 0. Reset mid-cycle drops o_wb_cyc/stb asynchronously.
// - All WB outputs registered. States: IDLE, BURST, RMW_RD, RMW_WR, DONE.
// - Beats N = max(1, 2^len / (DW/8)). N==1: CTI=CLASSIC, sel=i_biu_sel.
//   N>1: sel all-ones, CTI=INCREMENTING, CTI=END_OF_BURST on last beat, adr += DW/8 per beat.
// - Start adr = i_biu_addr with low log2(DW/8) bits cleared; N>1 also clears bits below 2^len.
// - IDLE: i_biu_en=1 & func READ/WRITE -> BURST, cyc=stb=1 next cycle; we=(func==WRITE).
//   func RMW -> RMW_RD (forced N=1, we=0). Reserved func 2'b11 -> DONE with o_biu_err=1, no WB cycle.
// - Write data: beat 0 sampled on IDLE accept cycle (o_biu_ack=1). Beat k+1 sampled when i_wb_ack
//   ends non-last beat k (o_biu_ack=1); requester advances i_biu_data the following cycle.
// - Reads: each i_wb_ack -> o_biu_ack=1, o_biu_data=i_wb_dat same cycle (combinational pass-through).
// - Stalls: outputs hold while stb=1 & no ack/err; no master timeout.
// - Last-beat ack in BURST -> DONE; cyc/stb deassert next cycle. Back-to-back beats: no idle cycles.
// - RMW_RD ack: capture i_wb_dat, merge i_biu_data on i_biu_sel lanes; cyc stays high (lock),
//   stb drops one cycle, -> RMW_WR with we=1, sel=all-ones, merged data. RMW_WR ack -> DONE.
//   o_biu_ack pulses on the RMW_RD ack (old data returned on o_biu_data).
// - i_wb_err in any active beat: terminate cycle, -> DONE with o_biu_err=1; no o_biu_ack that cycle.
//   i_wb_ack and i_wb_err together: err wins.
// - DONE: o_biu_done=1 for one cycle, -> IDLE. i_biu_en must drop the cycle after; a new request
//   is accepted earliest 2 cycles after o_biu_done.
// - i_biu_en dropping mid-request: ignored; request runs to completion.
// STRUCTURE
// - procyon_lib_pkg: add function pcyn_biu_len_to_beats(len, dw) and WB_SEL_ALL helper constant.
// - FSM state enum local to module. No sub-module; single FSM plus beat counter and address incrementer.
// TESTING
// - READ 4B @0x1004, ack 1 cycle after stb -> CTI=CLASSIC, sel=4'hF, one o_biu_ack, o_biu_done.
// - READ 32B @0x2010, DW=32 -> 8 beats adr 0x2000..0x201C, CTI=010 x7 then 111, 8 o_biu_acks.
// - WRITE 16B, slave inserts 3 wait states on beat 2 -> outputs held, data beats in order, done once.
// - RMW 1B @0x3003 sel=4'h8, data 0xAB000000, mem 0x11223344 -> write 0xAB223344, cyc high throughout.
// - READ 64B with i_wb_err on beat 3 -> 3 acks, cyc drops, o_biu_done & o_biu_err.
// - n_rst low mid-burst -> cyc/stb 0 immediately; after release IDLE, next request accepted normally.

Source files
------------

// File: rtl/procyon_lib_pkg.sv
// Shared Procyon BIU / Wishbone encodings and helpers used by the bus interface unit.
package procyon_lib_pkg;

  typedef enum logic [1:0] {
    PCYN_BIU_FUNC_READ  = 2'b00,
    PCYN_BIU_FUNC_WRITE = 2'b01,
    PCYN_BIU_FUNC_RMW   = 2'b10
  } pcyn_biu_func_t;

  typedef enum logic [2:0] {
    PCYN_BIU_LEN_1B   = 3'd0,
    PCYN_BIU_LEN_2B   = 3'd1,
    PCYN_BIU_LEN_4B   = 3'd2,
    PCYN_BIU_LEN_8B   = 3'd3,
    PCYN_BIU_LEN_16B  = 3'd4,
    PCYN_BIU_LEN_32B  = 3'd5,
    PCYN_BIU_LEN_64B  = 3'd6,
    PCYN_BIU_LEN_128B = 3'd7
  } pcyn_biu_len_t;

  localparam logic [2:0]  WB_CTI_CLASSIC = 3'b000;
  localparam logic [2:0]  WB_CTI_INCR    = 3'b010;
  localparam logic [2:0]  WB_CTI_EOB     = 3'b111;
  localparam logic [1:0]  WB_BTE_LINEAR  = 2'b00;
  // Widest supported bus is 128 bits; users slice the lanes they need.
  localparam logic [15:0] WB_SEL_ALL     = 16'hFFFF;

  // Bus beats needed for a 2^len byte request on a dw-bit bus (never fewer than one).
  function automatic logic [7:0] pcyn_biu_len_to_beats(input logic [2:0] len, input int dw);
    int bytes_v;
    int bpb_v;
    bytes_v = 1 << len;
    bpb_v   = dw / 8;
    if (bytes_v <= bpb_v) begin
      return 8'd1;
    end else begin
      return 8'(bytes_v / bpb_v);
    end
  endfunction

endpackage

// File: rtl/procyon_biu_wb_master.sv
// Wishbone B4 registered-feedback master: turns one BIU request into a classic,
// incrementing-burst or locked read-modify-write bus cycle.
module procyon_biu_wb_master
  import procyon_lib_pkg::*;
#(
  parameter int OPTN_DATA_WIDTH = 32,
  parameter int OPTN_ADDR_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         n_rst,
  input  logic                         i_biu_en,
  input  logic [1:0]                   i_biu_func,
  input  logic [2:0]                   i_biu_len,
  input  logic [OPTN_ADDR_WIDTH-1:0]   i_biu_addr,
  input  logic [OPTN_DATA_WIDTH/8-1:0] i_biu_sel,
  input  logic [OPTN_DATA_WIDTH-1:0]   i_biu_data,
  output logic                         o_biu_ack,
  output logic [OPTN_DATA_WIDTH-1:0]   o_biu_data,
  output logic                         o_biu_done,
  output logic                         o_biu_err,
  output logic                         o_wb_cyc,
  output logic                         o_wb_stb,
  output logic                         o_wb_we,
  output logic [2:0]                   o_wb_cti,
  output logic [1:0]                   o_wb_bte,
  output logic [OPTN_ADDR_WIDTH-1:0]   o_wb_adr,
  output logic [OPTN_DATA_WIDTH/8-1:0] o_wb_sel,
  output logic [OPTN_DATA_WIDTH-1:0]   o_wb_dat,
  input  logic                         i_wb_ack,
  input  logic                         i_wb_err,
  input  logic [OPTN_DATA_WIDTH-1:0]   i_wb_dat
);

  localparam int DW  = OPTN_DATA_WIDTH;
  localparam int AW  = OPTN_ADDR_WIDTH;
  localparam int BPB = DW / 8;
  localparam logic [AW-1:0]  LANE_MASK = AW'(BPB - 1);
  localparam logic [AW-1:0]  ADR_STEP  = AW'(BPB);
  localparam logic [BPB-1:0] SEL_ALL   = WB_SEL_ALL[BPB-1:0];

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BURST  = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_RMW_WR = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t         state_r, state_s;
  logic           cyc_r, cyc_s, stb_r, stb_s, we_r, we_s;
  logic [2:0]     cti_r, cti_s;
  logic [AW-1:0]  adr_r, adr_s;
  logic [BPB-1:0] sel_r, sel_s;
  logic [DW-1:0]  dat_r, dat_s;
  logic [7:0]     beats_r, beats_s, beat_cnt_r, beat_cnt_s;
  logic           err_r, err_s, hold_r, hold_s;

  logic           accept_s, biu_ack_s, wb_ack_s, wb_err_s, last_s;
  logic [7:0]     beats_req_s;
  logic [AW-1:0]  len_mask_s, start_adr_s;
  logic [DW-1:0]  merge_s;

  // Request decode: beat count, aligned start address and termination qualifiers.
  always_comb begin
    beats_req_s = pcyn_biu_len_to_beats(i_biu_len, DW);
    len_mask_s  = ~((AW'(1) << i_biu_len) - AW'(1));
    if ((beats_req_s != 8'd1) && (i_biu_func != PCYN_BIU_FUNC_RMW)) begin
      start_adr_s = i_biu_addr & ~LANE_MASK & len_mask_s;
    end else begin
      start_adr_s = i_biu_addr & ~LANE_MASK;
    end
    // The cycle after o_biu_done the requester is still dropping i_biu_en.
    accept_s = i_biu_en & ~hold_r;
    wb_err_s = stb_r & i_wb_err;
    wb_ack_s = stb_r & i_wb_ack & ~i_wb_err;
    last_s   = ((beat_cnt_r + 8'd1) == beats_r);
  end

  // RMW merge: requester bytes on selected lanes, old bus data elsewhere.
  always_comb begin
    merge_s = i_wb_dat;
    for (int i = 0; i < BPB; i++) begin
      if (i_biu_sel[i]) begin
        merge_s[8*i +: 8] = i_biu_data[8*i +: 8];
      end else begin
        merge_s[8*i +: 8] = i_wb_dat[8*i +: 8];
      end
    end
  end

  // Next-state and next bus-register values.
  always_comb begin
    state_s    = state_r;
    cyc_s      = cyc_r;
    stb_s      = stb_r;
    we_s       = we_r;
    cti_s      = cti_r;
    adr_s      = adr_r;
    sel_s      = sel_r;
    dat_s      = dat_r;
    beats_s    = beats_r;
    beat_cnt_s = beat_cnt_r;
    err_s      = err_r;
    biu_ack_s  = 1'b0;
    hold_s     = (state_r == ST_DONE);
    case (state_r)
      ST_IDLE: begin
        err_s = 1'b0;
        if (accept_s) begin
          adr_s      = start_adr_s;
          beat_cnt_s = 8'd0;
          beats_s    = 8'd1;
          cti_s      = WB_CTI_CLASSIC;
          sel_s      = SEL_ALL;
          dat_s      = {DW{1'b0}};
          we_s       = 1'b0;
          case (i_biu_func)
            PCYN_BIU_FUNC_READ, PCYN_BIU_FUNC_WRITE: begin
              state_s = ST_BURST;
              cyc_s   = 1'b1;
              stb_s   = 1'b1;
              beats_s = beats_req_s;
              if (beats_req_s == 8'd1) begin
                sel_s = i_biu_sel;
                cti_s = WB_CTI_CLASSIC;
              end else begin
                sel_s = SEL_ALL;
                cti_s = WB_CTI_INCR;
              end
              if (i_biu_func == PCYN_BIU_FUNC_WRITE) begin
                we_s      = 1'b1;
                dat_s     = i_biu_data;
                biu_ack_s = 1'b1;
              end else begin
                we_s = 1'b0;
              end
            end
            PCYN_BIU_FUNC_RMW: begin
              state_s = ST_RMW_RD;
              cyc_s   = 1'b1;
              stb_s   = 1'b1;
            end
            default: begin
              state_s = ST_DONE;
              err_s   = 1'b1;
            end
          endcase
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BURST: begin
        if (wb_err_s) begin
          cyc_s   = 1'b0;
          stb_s   = 1'b0;
          err_s   = 1'b1;
          state_s = ST_DONE;
        end else if (wb_ack_s) begin
          if (last_s) begin
            cyc_s     = 1'b0;
            stb_s     = 1'b0;
            state_s   = ST_DONE;
            biu_ack_s = ~we_r;
          end else begin
            biu_ack_s  = 1'b1;
            adr_s      = adr_r + ADR_STEP;
            beat_cnt_s = beat_cnt_r + 8'd1;
            cti_s      = ((beat_cnt_r + 8'd2) == beats_r) ? WB_CTI_EOB : WB_CTI_INCR;
            dat_s      = we_r ? i_biu_data : dat_r;
          end
        end else begin
          state_s = ST_BURST;
        end
      end
      ST_RMW_RD: begin
        if (wb_err_s) begin
          cyc_s   = 1'b0;
          stb_s   = 1'b0;
          err_s   = 1'b1;
          state_s = ST_DONE;
        end else if (wb_ack_s) begin
          // Keep cyc asserted so the read and write stay one locked cycle.
          biu_ack_s = 1'b1;
          stb_s     = 1'b0;
          we_s      = 1'b1;
          sel_s     = SEL_ALL;
          dat_s     = merge_s;
          state_s   = ST_RMW_WR;
        end else begin
          state_s = ST_RMW_RD;
        end
      end
      ST_RMW_WR: begin
        if (!stb_r) begin
          stb_s = 1'b1;
        end else if (wb_err_s) begin
          cyc_s   = 1'b0;
          stb_s   = 1'b0;
          err_s   = 1'b1;
          state_s = ST_DONE;
        end else if (wb_ack_s) begin
          cyc_s   = 1'b0;
          stb_s   = 1'b0;
          state_s = ST_DONE;
        end else begin
          state_s = ST_RMW_WR;
        end
      end
      ST_DONE: begin
        state_s    = ST_IDLE;
        we_s       = 1'b0;
        cti_s      = WB_CTI_CLASSIC;
        adr_s      = {AW{1'b0}};
        sel_s      = {BPB{1'b0}};
        dat_s      = {DW{1'b0}};
        beats_s    = 8'd0;
        beat_cnt_s = 8'd0;
      end
      default: begin
        state_s = ST_IDLE;
        cyc_s   = 1'b0;
        stb_s   = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Bus output, beat counter and status registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cyc_r      <= 1'b0;
      stb_r      <= 1'b0;
      we_r       <= 1'b0;
      cti_r      <= WB_CTI_CLASSIC;
      adr_r      <= {AW{1'b0}};
      sel_r      <= {BPB{1'b0}};
      dat_r      <= {DW{1'b0}};
      beats_r    <= 8'd0;
      beat_cnt_r <= 8'd0;
      err_r      <= 1'b0;
      hold_r     <= 1'b0;
    end else begin
      cyc_r      <= cyc_s;
      stb_r      <= stb_s;
      we_r       <= we_s;
      cti_r      <= cti_s;
      adr_r      <= adr_s;
      sel_r      <= sel_s;
      dat_r      <= dat_s;
      beats_r    <= beats_s;
      beat_cnt_r <= beat_cnt_s;
      err_r      <= err_s;
      hold_r     <= hold_s;
    end
  end

  assign o_wb_cyc   = cyc_r;
  assign o_wb_stb   = stb_r;
  assign o_wb_we    = we_r;
  assign o_wb_cti   = cti_r;
  assign o_wb_bte   = WB_BTE_LINEAR;
  assign o_wb_adr   = adr_r;
  assign o_wb_sel   = sel_r;
  assign o_wb_dat   = dat_r;
  assign o_biu_ack  = biu_ack_s;
  assign o_biu_data = biu_ack_s ? i_wb_dat : {DW{1'b0}};
  assign o_biu_done = (state_r == ST_DONE);
  assign o_biu_err  = (state_r == ST_DONE) & err_r;

endmodule

// File: tb/tb_procyon_biu_wb_master.sv
// Scoreboard bench for procyon_biu_wb_master: directed requests against a small
// Wishbone slave model; a negedge monitor pops expected beats, acks and completions.
module tb_procyon_biu_wb_master;

  logic        clk;
  logic        n_rst;
  logic        i_biu_en;
  logic [1:0]  i_biu_func;
  logic [2:0]  i_biu_len;
  logic [31:0] i_biu_addr;
  logic [3:0]  i_biu_sel;
  logic [31:0] i_biu_data;
  logic        o_biu_ack;
  logic [31:0] o_biu_data;
  logic        o_biu_done;
  logic        o_biu_err;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [2:0]  o_wb_cti;
  logic [1:0]  o_wb_bte;
  logic [31:0] o_wb_adr;
  logic [3:0]  o_wb_sel;
  logic [31:0] o_wb_dat;
  logic        i_wb_ack, i_wb_err;
  logic [31:0] i_wb_dat;

  procyon_biu_wb_master #(.OPTN_DATA_WIDTH(32), .OPTN_ADDR_WIDTH(32)) dut (
    .clk(clk), .n_rst(n_rst),
    .i_biu_en(i_biu_en), .i_biu_func(i_biu_func), .i_biu_len(i_biu_len),
    .i_biu_addr(i_biu_addr), .i_biu_sel(i_biu_sel), .i_biu_data(i_biu_data),
    .o_biu_ack(o_biu_ack), .o_biu_data(o_biu_data), .o_biu_done(o_biu_done),
    .o_biu_err(o_biu_err),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we), .o_wb_cti(o_wb_cti),
    .o_wb_bte(o_wb_bte), .o_wb_adr(o_wb_adr), .o_wb_sel(o_wb_sel), .o_wb_dat(o_wb_dat),
    .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_dat(i_wb_dat)
  );

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [2:0]  cti;
    logic [3:0]  sel;
    bit          chk_sel;
    logic [31:0] dat;
  } wb_exp_t;

  typedef struct {
    bit err;
    int nacks;
  } done_exp_t;

  wb_exp_t     exp_wb[$];
  logic [31:0] exp_rd[$];
  done_exp_t   exp_done[$];

  int total = 0;
  int bad   = 0;
  int ack_cnt = 0;
  bit cur_rd = 1'b0;

  // slave model knobs
  int base_wait  = 0;
  int stall_beat = -1;
  int stall_n    = 0;
  int err_beat   = -1;
  logic [31:0] mem [int];
  logic [31:0] wdata [32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    int key;
    key = int'(a >> 2);
    if (mem.exists(key)) return mem[key];
    else return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  // Wishbone slave: registered feedback, configurable waits and error injection.
  initial begin
    int sb_beat;
    int sb_w;
    int need;
    int key;
    logic [31:0] w;
    i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_dat = 32'h0;
    sb_beat = 0; sb_w = 0;
    forever begin
      @(posedge clk); #1;
      i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_dat = 32'h0;
      if (!n_rst || !o_wb_cyc) begin
        sb_beat = 0; sb_w = 0;
      end else if (o_wb_stb) begin
        need = base_wait + ((sb_beat == stall_beat) ? stall_n : 0);
        if (sb_w < need) begin
          sb_w++;
        end else begin
          sb_w = 0;
          if (sb_beat == err_beat) begin
            i_wb_err = 1'b1;
          end else begin
            i_wb_ack = 1'b1;
            if (o_wb_we) begin
              key = int'(o_wb_adr >> 2);
              w = rd_model(o_wb_adr);
              for (int i = 0; i < 4; i++) if (o_wb_sel[i]) w[8*i +: 8] = o_wb_dat[8*i +: 8];
              mem[key] = w;
            end else begin
              i_wb_dat = rd_model(o_wb_adr);
            end
          end
          sb_beat++;
        end
      end
    end
  end

  // Monitor: compares every terminated bus beat, stalled beat, BIU ack and completion.
  always @(negedge clk) begin
    wb_exp_t   e;
    done_exp_t d;
    logic [31:0] r;
    if (n_rst) begin
      if (o_wb_cyc && o_wb_stb) begin
        if (i_wb_ack || i_wb_err) begin
          if (exp_wb.size() == 0) begin
            chk("wb_unexpected_beat", 64'd1, 64'd0);
          end else begin
            e = exp_wb.pop_front();
            chk("wb_adr", o_wb_adr, e.adr);
            chk("wb_we", o_wb_we, e.we);
            chk("wb_cti", o_wb_cti, e.cti);
            chk("wb_bte", o_wb_bte, 2'b00);
            if (e.chk_sel) chk("wb_sel", o_wb_sel, e.sel);
            if (e.we) chk("wb_dat", o_wb_dat, e.dat);
          end
        end else if (exp_wb.size() > 0) begin
          chk("stall_adr_hold", o_wb_adr, exp_wb[0].adr);
          if (exp_wb[0].we) chk("stall_dat_hold", o_wb_dat, exp_wb[0].dat);
        end
      end
      if (o_biu_ack) begin
        ack_cnt++;
        if (cur_rd) begin
          if (exp_rd.size() == 0) begin
            chk("biu_unexpected_rd_ack", 64'd1, 64'd0);
          end else begin
            r = exp_rd.pop_front();
            chk("biu_rd_data", o_biu_data, r);
          end
        end
      end
      if (o_biu_done) begin
        if (exp_done.size() == 0) begin
          chk("biu_unexpected_done", 64'd1, 64'd0);
        end else begin
          d = exp_done.pop_front();
          chk("biu_err", o_biu_err, d.err);
          chk("biu_ack_count", ack_cnt, d.nacks);
          chk("wb_cyc_after_done", o_wb_cyc, 1'b0);
        end
        ack_cnt = 0;
      end
    end
  end

  // Queue expected bus beats (n_push of an n-beat transfer) and matching read data.
  task automatic push_burst(input logic [31:0] base, input int n, input int n_push,
                            input logic we, input logic [3:0] sel, input bit chk_sel,
                            input bit rd);
    wb_exp_t e;
    for (int k = 0; k < n_push; k++) begin
      e.adr = base + 32'(4 * k);
      e.we  = we;
      e.cti = (n == 1) ? 3'b000 : ((k == n - 1) ? 3'b111 : 3'b010);
      e.sel = sel;
      e.chk_sel = chk_sel;
      e.dat = wdata[k];
      exp_wb.push_back(e);
      if (rd) exp_rd.push_back(rd_model(e.adr));
    end
  endtask

  task automatic push_done(input bit err, input int nacks);
    done_exp_t d;
    d.err = err;
    d.nacks = nacks;
    exp_done.push_back(d);
  endtask

  // Requester: holds i_biu_en, advances write data after each ack, drops en after done.
  task automatic run_req(input logic [1:0] f, input logic [2:0] l, input logic [31:0] a,
                         input logic [3:0] s, input bit chk_cyc);
    int k;
    bit got, ack_v, done_v, dropped;
    k = 0; got = 1'b0; dropped = 1'b0;
    @(posedge clk); #1;
    i_biu_en = 1'b1; i_biu_func = f; i_biu_len = l; i_biu_addr = a; i_biu_sel = s;
    i_biu_data = wdata[0];
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      ack_v = o_biu_ack; done_v = o_biu_done;
      if (c > 0 && !done_v && !o_wb_cyc) dropped = 1'b1;
      @(posedge clk); #1;
      if (ack_v) begin
        k++;
        i_biu_data = (k < 32) ? wdata[k] : 32'h0;
      end
      if (done_v) begin
        i_biu_en = 1'b0;
        got = 1'b1;
      end
    end
    i_biu_en = 1'b0;
    chk("done_within_budget", got, 1'b1);
    if (chk_cyc) chk("rmw_cyc_held", dropped, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst = 1'b0; i_biu_en = 1'b0; i_biu_func = 2'b00; i_biu_len = 3'd0;
    i_biu_addr = 32'h0; i_biu_sel = 4'h0; i_biu_data = 32'h0;
    for (int i = 0; i < 32; i++) wdata[i] = 32'h0;
    mem[32'h3000 >> 2] = 32'h1122_3344;
    #22;
    chk("rst_cyc", o_wb_cyc, 1'b0);
    chk("rst_stb", o_wb_stb, 1'b0);
    chk("rst_we", o_wb_we, 1'b0);
    chk("rst_adr", o_wb_adr, 32'h0);
    chk("rst_sel", o_wb_sel, 4'h0);
    chk("rst_cti", o_wb_cti, 3'b000);
    chk("rst_done", o_biu_done, 1'b0);
    chk("rst_err", o_biu_err, 1'b0);
    chk("rst_ack", o_biu_ack, 1'b0);
    n_rst = 1'b1;
    repeat (2) @(posedge clk);

    // READ 4B @0x1004, one wait state
    base_wait = 1; cur_rd = 1'b1;
    push_burst(32'h1004, 1, 1, 1'b0, 4'hF, 1'b1, 1'b1);
    push_done(1'b0, 1);
    run_req(2'b00, 3'd2, 32'h1004, 4'hF, 1'b0);
    base_wait = 0;

    // READ 32B @0x2010 -> 8 beats from 0x2000
    push_burst(32'h2000, 8, 8, 1'b0, 4'hF, 1'b1, 1'b1);
    push_done(1'b0, 8);
    run_req(2'b00, 3'd5, 32'h2010, 4'h0, 1'b0);

    // READ 8B @0x900C -> 2 beats from 0x9008
    push_burst(32'h9008, 2, 2, 1'b0, 4'hF, 1'b1, 1'b1);
    push_done(1'b0, 2);
    run_req(2'b00, 3'd3, 32'h900C, 4'h0, 1'b0);

    // WRITE 16B @0x4000, 3 wait states on beat 2
    cur_rd = 1'b0;
    wdata[0] = 32'h1111_1111; wdata[1] = 32'h2222_2222;
    wdata[2] = 32'h3333_3333; wdata[3] = 32'h4444_4444;
    stall_beat = 2; stall_n = 3;
    push_burst(32'h4000, 4, 4, 1'b1, 4'hF, 1'b1, 1'b0);
    push_done(1'b0, 4);
    run_req(2'b01, 3'd4, 32'h4000, 4'h0, 1'b0);
    stall_beat = -1; stall_n = 0;

    // read back the third written word
    cur_rd = 1'b1;
    push_burst(32'h4008, 1, 1, 1'b0, 4'hF, 1'b1, 1'b0);
    exp_rd.push_back(32'h3333_3333);
    push_done(1'b0, 1);
    run_req(2'b00, 3'd2, 32'h4008, 4'hF, 1'b0);

    // WRITE 1B @0x8001 lane 1
    cur_rd = 1'b0;
    wdata[0] = 32'h0000_5A00;
    push_burst(32'h8000, 1, 1, 1'b1, 4'h2, 1'b1, 1'b0);
    push_done(1'b0, 1);
    run_req(2'b01, 3'd0, 32'h8001, 4'h2, 1'b0);

    // RMW 1B @0x3003 lane 3 over 0x11223344
    cur_rd = 1'b1;
    wdata[0] = 32'hAB00_0000;
    push_burst(32'h3000, 1, 1, 1'b0, 4'hF, 1'b0, 1'b0);
    exp_rd.push_back(32'h1122_3344);
    wdata[0] = 32'hAB22_3344;
    push_burst(32'h3000, 1, 1, 1'b1, 4'hF, 1'b1, 1'b0);
    wdata[0] = 32'hAB00_0000;
    push_done(1'b0, 1);
    run_req(2'b10, 3'd0, 32'h3003, 4'h8, 1'b1);

    // READ 64B @0x5000 with bus error on beat 3
    err_beat = 3;
    push_burst(32'h5000, 16, 4, 1'b0, 4'hF, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) exp_rd.push_back(rd_model(32'h5000 + 32'(4 * k)));
    push_done(1'b1, 3);
    run_req(2'b00, 3'd6, 32'h5000, 4'h0, 1'b0);
    err_beat = -1;

    // reserved function code: error completion, no bus cycle
    cur_rd = 1'b0;
    push_done(1'b1, 0);
    run_req(2'b11, 3'd2, 32'h0100, 4'hF, 1'b0);

    // reset in the middle of a 128B burst
    cur_rd = 1'b1;
    push_burst(32'h6000, 32, 32, 1'b0, 4'hF, 1'b1, 1'b1);
    @(posedge clk); #1;
    i_biu_en = 1'b1; i_biu_func = 2'b00; i_biu_len = 3'd7; i_biu_addr = 32'h6000; i_biu_sel = 4'h0;
    repeat (5) @(posedge clk);
    #3;
    n_rst = 1'b0; i_biu_en = 1'b0;
    #1;
    chk("midrst_cyc", o_wb_cyc, 1'b0);
    chk("midrst_stb", o_wb_stb, 1'b0);
    exp_wb.delete(); exp_rd.delete(); ack_cnt = 0;
    repeat (2) @(posedge clk);
    #2 n_rst = 1'b1;
    push_burst(32'h7008, 1, 1, 1'b0, 4'hF, 1'b1, 1'b1);
    push_done(1'b0, 1);
    run_req(2'b00, 3'd2, 32'h7008, 4'hF, 1'b0);

    repeat (3) @(posedge clk);
    chk("left_wb_beats", exp_wb.size(), 0);
    chk("left_rd_data", exp_rd.size(), 0);
    chk("left_done", exp_done.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
